// File: rtl/writeback_queue.sv
// In-order writeback queue in front of a small register file; read forwarding is selected by WB_BYPASS_EN.
// Accepted results commit one cycle later at the earliest; in_ready drops when full or in reset, wb_stall holds the head.
module writeback_queue #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2,
    parameter int DEPTH    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0] in_data,
    input  logic              wb_stall,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              commit_valid,
    output logic [ADDR_W-1:0] commit_rd,
    output logic [ADDR_W:0]   pending,
    output logic              hazard
);

    localparam int                PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   FULL  = (ADDR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0]  LAST  = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W:0]    WRAP  = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] regs   [NUM_REGS];
    logic [ADDR_W-1:0] q_rd   [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [ADDR_W:0]   count;
    logic              enq, commit;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign in_ready = !reset && (count < FULL);
    assign enq      = in_valid && in_ready;
    assign commit   = !reset && (count != '0) && !wb_stall;
    assign pending  = count;

    always_ff @(posedge clk) begin
        if (reset) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            commit_valid <= 1'b0;
            commit_rd    <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            if (enq) tail <= next_ptr(tail);
            if (commit) begin
                head      <= next_ptr(head);
                commit_rd <= q_rd[head];
                // Register 0 is hardwired: the entry still pops and pulses commit_valid.
                if (q_rd[head] != '0) regs[q_rd[head]] <= q_data[head];
            end
            commit_valid <= commit;
            case ({enq, commit})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_rd[tail]   <= in_rd;
            q_data[tail] <= in_data;
        end
    end

    logic              rs_hit, rt_hit;
    logic [PTR_W:0]    idx_sum;
    logic [PTR_W-1:0]  idx;
`ifdef WB_BYPASS_EN
    logic [DATA_W-1:0] rs_fwd, rt_fwd;
`endif

    // Walk oldest to youngest so the last match seen is the youngest pending write.
    always_comb begin
        rs_hit  = 1'b0;
        rt_hit  = 1'b0;
        idx_sum = '0;
        idx     = '0;
`ifdef WB_BYPASS_EN
        rs_fwd  = '0;
        rt_fwd  = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx_sum = {1'b0, head} + (PTR_W+1)'(k);
            if (idx_sum >= WRAP) idx_sum = idx_sum - WRAP;
            idx = idx_sum[PTR_W-1:0];
            if ((ADDR_W+1)'(k) < count) begin
                if (q_rd[idx] == rs_addr) begin
                    rs_hit = 1'b1;
`ifdef WB_BYPASS_EN
                    rs_fwd = q_data[idx];
`endif
                end
                if (q_rd[idx] == rt_addr) begin
                    rt_hit = 1'b1;
`ifdef WB_BYPASS_EN
                    rt_fwd = q_data[idx];
`endif
                end
            end
        end
    end

`ifdef WB_BYPASS_EN
    assign rs_data = (rs_addr == '0) ? '0 : (rs_hit ? rs_fwd : regs[rs_addr]);
    assign rt_data = (rt_addr == '0) ? '0 : (rt_hit ? rt_fwd : regs[rt_addr]);
    assign hazard  = 1'b0;
`else
    assign rs_data = (rs_addr == '0) ? '0 : regs[rs_addr];
    assign rt_data = (rt_addr == '0) ? '0 : regs[rt_addr];
    assign hazard  = ((rs_addr != '0) && rs_hit) || ((rt_addr != '0) && rt_hit);
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed table, hand-written corner sequences, then random traffic against a queue model.
module tb_writeback_queue;
    localparam int DW = 16;
    localparam int AW = 2;
    localparam int D  = 2;

    logic          clk = 1'b0;
    logic          reset, in_valid, wb_stall;
    logic [AW-1:0] in_rd, rs_addr, rt_addr;
    logic [DW-1:0] in_data;
    logic          in_ready, commit_valid, hazard;
    logic [DW-1:0] rs_data, rt_data;
    logic [AW-1:0] commit_rd;
    logic [AW:0]   pending;

    always #5 clk = ~clk;

    writeback_queue #(.DATA_W(DW), .NUM_REGS(4), .ADDR_W(AW), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_data(in_data), .wb_stall(wb_stall),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .pending(pending), .hazard(hazard)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of pending writes plus an array of committed registers.
    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] d;
    } ent_t;
    ent_t          mq[$];
    logic [DW-1:0] mregs[4];
    logic          mcv;
    logic [AW-1:0] mcrd;

    task automatic model_edge();
        bit   c, e;
        ent_t h;
        if (reset) begin
            mq.delete();
            for (int i = 0; i < 4; i++) mregs[i] = '0;
            mcv  = 1'b0;
            mcrd = '0;
        end else begin
            c = (mq.size() > 0) && !wb_stall;
            e = in_valid && (mq.size() < D);
            if (c) begin
                h = mq.pop_front();
                if (h.rd != 0) mregs[h.rd] = h.d;
                mcrd = h.rd;
            end
            mcv = c;
            if (e) mq.push_back('{in_rd, in_data});
        end
    endtask

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef WB_BYPASS_EN
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].rd == a) return mq[i].d;
`endif
        return mregs[a];
    endfunction

    function automatic logic model_hazard();
`ifdef WB_BYPASS_EN
        return 1'b0;
`else
        foreach (mq[i])
            if ((rs_addr != 0 && mq[i].rd == rs_addr) || (rt_addr != 0 && mq[i].rd == rt_addr)) return 1'b1;
        return 1'b0;
`endif
    endfunction

    task automatic cyc(input bit r, input bit v, input logic [AW-1:0] rd, input logic [DW-1:0] d, input bit s);
        reset    = r;
        in_valid = v;
        in_rd    = rd;
        in_data  = d;
        wb_stall = s;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          rst, vld;
        logic [AW-1:0] rd;
        logic [DW-1:0] dat;
        logic          stall;
        logic [AW-1:0] rs;
        logic [AW:0]   e_pend;
        logic          e_rdy, e_cv;
        logic [AW-1:0] e_crd;
        logic [DW-1:0] e_rs;
    } vec_t;
    vec_t tbl[18];

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0;
        wb_stall = 1'b0; rs_addr = '0; rt_addr = '0;
        mcv = 1'b0; mcrd = '0;
        for (int i = 0; i < 4; i++) mregs[i] = '0;

        //         rst   vld   rd     data      stall rs      pend  rdy   cv    crd    rs_data
        tbl[0]  = '{1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd1, 3'd0, 1'b0, 1'b0, 2'd0, 16'h0000};
        tbl[1]  = '{1'b0, 1'b1, 2'd1, 16'h0001, 1'b0, 2'd0, 3'd1, 1'b1, 1'b0, 2'd0, 16'h0000};
        tbl[2]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd1, 3'd0, 1'b1, 1'b1, 2'd1, 16'h0001};
        tbl[3]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd1, 3'd0, 1'b1, 1'b0, 2'd1, 16'h0001};
        tbl[4]  = '{1'b0, 1'b1, 2'd0, 16'hFFFF, 1'b0, 2'd0, 3'd1, 1'b1, 1'b0, 2'd1, 16'h0000};
        tbl[5]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 3'd0, 1'b1, 1'b1, 2'd0, 16'h0000};
        tbl[6]  = '{1'b0, 1'b1, 2'd3, 16'h1111, 1'b1, 2'd1, 3'd1, 1'b1, 1'b0, 2'd0, 16'h0001};
        tbl[7]  = '{1'b0, 1'b1, 2'd3, 16'h2222, 1'b1, 2'd1, 3'd2, 1'b0, 1'b0, 2'd0, 16'h0001};
        tbl[8]  = '{1'b0, 1'b1, 2'd3, 16'h3333, 1'b1, 2'd1, 3'd2, 1'b0, 1'b0, 2'd0, 16'h0001};
        tbl[9]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd1, 3'd1, 1'b1, 1'b1, 2'd3, 16'h0001};
        tbl[10] = '{1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd3, 3'd0, 1'b1, 1'b1, 2'd3, 16'h2222};
        tbl[11] = '{1'b0, 1'b1, 2'd2, 16'h000A, 1'b0, 2'd3, 3'd1, 1'b1, 1'b0, 2'd3, 16'h2222};
        tbl[12] = '{1'b0, 1'b1, 2'd2, 16'h000B, 1'b0, 2'd3, 3'd1, 1'b1, 1'b1, 2'd2, 16'h2222};
        tbl[13] = '{1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd2, 3'd0, 1'b1, 1'b1, 2'd2, 16'h000B};
        tbl[14] = '{1'b0, 1'b1, 2'd1, 16'h5555, 1'b1, 2'd3, 3'd1, 1'b1, 1'b0, 2'd2, 16'h2222};
        tbl[15] = '{1'b0, 1'b1, 2'd1, 16'h6666, 1'b1, 2'd3, 3'd2, 1'b0, 1'b0, 2'd2, 16'h2222};
        tbl[16] = '{1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd2, 3'd0, 1'b0, 1'b0, 2'd0, 16'h0000};
        tbl[17] = '{1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd3, 3'd0, 1'b1, 1'b0, 2'd0, 16'h0000};

        for (int i = 0; i < 18; i++) begin
            rs_addr = tbl[i].rs;
            rt_addr = '0;
            cyc(tbl[i].rst, tbl[i].vld, tbl[i].rd, tbl[i].dat, tbl[i].stall);
            check($sformatf("vec%0d pending", i), 32'(pending), 32'(tbl[i].e_pend));
            check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
            check($sformatf("vec%0d commit_valid", i), 32'(commit_valid), 32'(tbl[i].e_cv));
            check($sformatf("vec%0d commit_rd", i), 32'(commit_rd), 32'(tbl[i].e_crd));
            check($sformatf("vec%0d rs_data", i), 32'(rs_data), 32'(tbl[i].e_rs));
        end

        // Two stalled writes to the same register: forwarding/hazard, full hold, younger value wins.
        rs_addr = '0;
        rt_addr = 2'd2;
        cyc(1'b1, 1'b0, 2'd0, 16'h0000, 1'b0);
        cyc(1'b0, 1'b1, 2'd2, 16'h000A, 1'b1);
        cyc(1'b0, 1'b1, 2'd2, 16'h000B, 1'b1);
        cyc(1'b0, 1'b1, 2'd3, 16'h0C0C, 1'b1);
        check("stall pending", 32'(pending), 32'd2);
        check("stall in_ready", 32'(in_ready), 32'd0);
        check("stall rs0", 32'(rs_data), 32'd0);
`ifdef WB_BYPASS_EN
        check("fwd rt_data", 32'(rt_data), 32'h000B);
        check("fwd hazard", 32'(hazard), 32'd0);
`else
        check("nofwd rt_data", 32'(rt_data), 32'h0000);
        check("nofwd hazard", 32'(hazard), 32'd1);
`endif
        cyc(1'b0, 1'b0, 2'd0, 16'h0000, 1'b0);
        check("release cv", 32'(commit_valid), 32'd1);
        check("release crd", 32'(commit_rd), 32'd2);
        cyc(1'b0, 1'b0, 2'd0, 16'h0000, 1'b0);
        check("younger wins", 32'(rt_data), 32'h000B);
        check("drained", 32'(pending), 32'd0);

        // Random traffic against the model, with occasional resets.
        for (int n = 0; n < 400; n++) begin
            rs_addr = AW'($urandom_range(0, 3));
            rt_addr = AW'($urandom_range(0, 3));
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 6), AW'($urandom_range(0, 3)),
                DW'($urandom), ($urandom_range(0, 9) < 4));
            check("rnd pending", 32'(pending), 32'(mq.size()));
            check("rnd in_ready", 32'(in_ready), 32'(!reset && mq.size() < D));
            check("rnd commit_valid", 32'(commit_valid), 32'(mcv));
            check("rnd commit_rd", 32'(commit_rd), 32'(mcrd));
            check("rnd rs_data", 32'(rs_data), 32'(model_read(rs_addr)));
            check("rnd rt_data", 32'(rt_data), 32'(model_read(rt_addr)));
            check("rnd hazard", 32'(hazard), 32'(model_hazard()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter DATA_W, default 16, is the result and register width in bits.
REQ-002 Parameter NUM_REGS, default 4, is the register count; register 0 reads as zero.
REQ-003 Parameter ADDR_W, default 2, is the register-address width; it SHALL satisfy 2**ADDR_W = NUM_REGS.
REQ-004 Parameter DEPTH, default 2, is the number of queue entries.
REQ-005 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-006 reset  input  1  is a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-007 in_valid  input  1  indicates an execute-stage result (e.g. SLTI rt value) is offered.
REQ-008 in_ready  output  1  indicates the queue can accept an offered result this cycle.
REQ-009 in_rd  input  ADDR_W  is the destination register of the offered result.
REQ-010 in_data  input  DATA_W  is the offered result value.
REQ-011 wb_stall  input  1  blocks commit from the queue to the register file when high.
REQ-012 rs_addr, rt_addr  input  ADDR_W each  are the read-port addresses.
REQ-013 rs_data, rt_data  output  DATA_W each  are the read-port data.
REQ-014 commit_valid  output  1  pulses for one cycle when the head entry commits.
REQ-015 commit_rd  output  ADDR_W  is the register written by the last commit.
REQ-016 pending  output  ADDR_W+1  is the current queue occupancy, 0..DEPTH.
REQ-017 hazard  output  1  flags that a read address matches a pending entry that is not forwarded.

Function
REQ-018 A transfer occurs on a rising edge with in_valid=1, in_ready=1 and reset=0; in_rd/in_data SHALL be enqueued at the tail.
REQ-019 in_ready SHALL equal (pending < DEPTH) and SHALL be combinational from registered occupancy only, with no same-cycle pass-through when full.
REQ-020 A commit occurs on a rising edge with pending > 0 and wb_stall=0; the head entry SHALL be written to the register file and popped.
REQ-021 A commit with rd=0 SHALL pop the entry, pulse commit_valid, and leave register 0 at zero.
REQ-022 Simultaneous enqueue and commit SHALL leave pending unchanged and preserve FIFO order.
REQ-023 Entries SHALL commit strictly in arrival order, at most one per cycle.
REQ-024 The minimum latency from accept at edge N to register-file update SHALL be edge N+1.
REQ-025 commit_valid and commit_rd SHALL be registered; commit_valid is high for exactly the cycle after each commit edge, otherwise 0.
REQ-026 Read ports SHALL be combinational; address 0 SHALL always return 0.
REQ-027 When two pending entries target the same register, the register file SHALL end with the younger value.
REQ-028 The head and tail pointers SHALL wrap modulo DEPTH.
REQ-029 Asserting wb_stall with pending = DEPTH SHALL hold in_ready low until a commit occurs.

Reset
REQ-030 With reset high at an edge: pending=0, pointers=0, all registers=0, commit_valid=0, commit_rd=0.
REQ-031 Reset SHALL override a concurrent enqueue or commit; in-flight entries are discarded.
REQ-032 in_ready SHALL be 0 while reset is high.

Configuration
REQ-033 Macro WB_BYPASS_EN SHALL select the read-forwarding behaviour.
REQ-034 With WB_BYPASS_EN defined, a nonzero read address matching pending entries SHALL return the youngest matching entry's data, and hazard SHALL be 0.
REQ-035 Without WB_BYPASS_EN, reads SHALL return register-file contents only, and hazard SHALL be 1 when a nonzero rs_addr or rt_addr matches any pending entry.

Verification
REQ-036 Reset, then enqueue rd=1 data=0x0001 -> pending=1; next edge commit_valid=1, commit_rd=1, and rs_addr=1 reads 0x0001.
REQ-037 wb_stall=1, enqueue 0x1111 then 0x2222 -> pending=2, in_ready=0; third offer is not accepted; release stall -> commits in order 0x1111, 0x2222.
REQ-038 Enqueue rd=0 data=0xFFFF -> commit_valid pulses, and rs_addr=0 still reads 0x0000.
REQ-039 With pending=1, enqueue and commit on the same edge -> pending stays 1 and data order is preserved.
REQ-040 With stall high, enqueue rd=2 values 0x000A then 0x000B -> with WB_BYPASS_EN, rt_addr=2 reads 0x000B and hazard=0; without it, rt_addr reads 0x0000 and hazard=1.
REQ-041 With pending=2, assert reset for one edge -> pending=0, all registers 0, no commit_valid pulse.
